// File: rtl/jp_scan_ctrl.sv
// Dual NES-style joypad scanner: latches both pads, clocks out 8 bits each,
// and publishes the button bytes atomically once a full scan has completed.
module jp_scan_ctrl #(
   parameter int PHASE_CYCLES = 16,
   parameter int AUTO_PERIOD  = 833333
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       poll_req,
   input  logic       auto_en,
   input  logic       jp_data1,
   input  logic       jp_data2,
   output logic       jp_latch,
   output logic       jp_clk,
   output logic [7:0] jp1_state,
   output logic [7:0] jp2_state,
   output logic       state_vld,
   output logic       busy
);

   localparam int TW = $clog2(AUTO_PERIOD);

   typedef enum logic [2:0] {IDLE, LATCH_HI, LATCH_LO, CLK_HI, CLK_LO} state_t;

   state_t        state_q, state_d;
   logic [7:0]    phase_q, phase_d;
   logic [2:0]    bit_q, bit_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          pending_q, pending_d;
   logic          d1_meta_q, d1_sync_q, d2_meta_q, d2_sync_q;
   logic [7:0]    shadow1_q, shadow1_d, shadow2_q, shadow2_d;
   logic [7:0]    jp1_q, jp1_d, jp2_q, jp2_d;
   logic          latch_q, latch_d, clk_q, clk_d;
   logic          busy_q, busy_d, vld_q, vld_d;
   logic          auto_tick, start, phase_last;

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      timer_d   = timer_q;
      shadow1_d = shadow1_q;
      shadow2_d = shadow2_q;
      jp1_d     = jp1_q;
      jp2_d     = jp2_q;
      latch_d   = latch_q;
      clk_d     = clk_q;
      busy_d    = busy_q;
      vld_d     = 1'b0;
      auto_tick = 1'b0;

      if (!auto_en) begin
         timer_d = '0;
      end else if (timer_q == TW'(AUTO_PERIOD - 1)) begin
         timer_d   = '0;
         auto_tick = 1'b1;
      end else begin
         timer_d = timer_q + 1'b1;
      end

      start      = (state_q == IDLE) && pending_q;
      pending_d  = (pending_q & ~start) | poll_req | auto_tick;
      phase_last = (phase_q == 8'(PHASE_CYCLES - 1));

      if (state_q != IDLE)
         phase_d = phase_last ? 8'd0 : phase_q + 8'd1;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LATCH_HI;
               latch_d = 1'b1;
               busy_d  = 1'b1;
               bit_d   = 3'd0;
               phase_d = 8'd0;
            end
         end
         LATCH_HI: begin
            if (phase_last) begin
               state_d = LATCH_LO;
               latch_d = 1'b0;
            end
         end
         LATCH_LO: begin
            if (phase_last) begin
               shadow1_d[bit_q] = ~d1_sync_q;
               shadow2_d[bit_q] = ~d2_sync_q;
               bit_d            = bit_q + 3'd1;
               state_d          = CLK_HI;
               clk_d            = 1'b1;
            end
         end
         CLK_HI: begin
            if (phase_last) begin
               state_d = CLK_LO;
               clk_d   = 1'b0;
            end
         end
         CLK_LO: begin
            if (phase_last) begin
               shadow1_d[bit_q] = ~d1_sync_q;
               shadow2_d[bit_q] = ~d2_sync_q;
               bit_d            = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  // Publish from the just-updated shadows so bit 7 lands in the same edge.
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  vld_d   = 1'b1;
                  jp1_d   = shadow1_d;
                  jp2_d   = shadow2_d;
               end else begin
                  state_d = CLK_HI;
                  clk_d   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         bit_q     <= '0;
         timer_q   <= '0;
         pending_q <= 1'b0;
         d1_meta_q <= 1'b0;
         d1_sync_q <= 1'b0;
         d2_meta_q <= 1'b0;
         d2_sync_q <= 1'b0;
         shadow1_q <= '0;
         shadow2_q <= '0;
         jp1_q     <= '0;
         jp2_q     <= '0;
         latch_q   <= 1'b0;
         clk_q     <= 1'b0;
         busy_q    <= 1'b0;
         vld_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         timer_q   <= timer_d;
         pending_q <= pending_d;
         d1_meta_q <= jp_data1;
         d1_sync_q <= d1_meta_q;
         d2_meta_q <= jp_data2;
         d2_sync_q <= d2_meta_q;
         shadow1_q <= shadow1_d;
         shadow2_q <= shadow2_d;
         jp1_q     <= jp1_d;
         jp2_q     <= jp2_d;
         latch_q   <= latch_d;
         clk_q     <= clk_d;
         busy_q    <= busy_d;
         vld_q     <= vld_d;
      end
   end

   assign jp_latch  = latch_q;
   assign jp_clk    = clk_q;
   assign jp1_state = jp1_q;
   assign jp2_state = jp2_q;
   assign state_vld = vld_q;
   assign busy      = busy_q;

endmodule
